spi_slave_tx_rx: RTL and testbench

SPI responder (slave) byte engine, the far end of the team's SPI master: it sits behind a peripheral register file and exchanges full-duplex bytes with an external SPI master. All SPI pins are oversampled in the system clock domain. SPI modes 0–3 and MSB/LSB-first ordering are supported. A single-entry transmit holding register allows back-to-back bytes within one chip-select frame.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave_tx_rx.sv | 184 ++++++++++++++++++
 tb/tb_spi_slave_tx_rx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame state encoding and the byte sent when the
// transmit holding register runs dry.
package spi_pkg;

  typedef enum logic {
    IDLE_s   = 1'b0,
    ACTIVE_s = 1'b1
  } spi_state_e;

  localparam logic [7:0] UDR_BYTE = 8'h00;

  function automatic logic out_bit(input logic [7:0] sh, input logic msb_first);
    return msb_first ? sh[7] : sh[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one SPI pin followed by an edge-detect register
// that produces single-cycle rise/fall pulses in the system clock domain.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_tx_rx.sv
// SPI responder byte engine: oversampled SCK/CS/MOSI, modes 0-3, MSB/LSB first,
// single-entry transmit holding register for back-to-back bytes in a frame.
module spi_slave_tx_rx
  import spi_pkg::*;
#(
  parameter int sync_st = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       msb_lsb_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_wr_i,
  output logic       tx_full_o,
  output logic       tx_udr_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       spi_sck_i,
  input  logic       spi_cs_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o
);

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(sync_st), .RST_VAL(1'b0)) u_sck_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (spi_sck_i),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.STAGES(sync_st), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (spi_cs_i),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // MOSI shares the SCK synchronizer depth so data lines up with the edge pulse
  logic [sync_st-1:0] mosi_q;
  logic [sync_st-1:0] mosi_d;
  logic               mosi_s;

  assign mosi_d = {mosi_q[sync_st-2:0], spi_mosi_i};
  assign mosi_s = mosi_q[sync_st-1];

  spi_state_e state_q, state_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       msb_q, msb_d;
  logic [2:0] bit_c_q, bit_c_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_full_q, tx_full_d;
  logic       tx_udr_q, tx_udr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       done_q, done_d;
  logic       miso_q, miso_d;

  logic active, frame_start, frame_end;
  logic lead, trail, sample, drive, load, wr_acc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_s:   if (cs_fall) state_d = ACTIVE_s;
      ACTIVE_s: if (cs_rise) state_d = IDLE_s;
    endcase
  end

  assign active      = (state_q == ACTIVE_s);
  assign frame_start = ~active & cs_fall;
  assign frame_end   = active & cs_rise;

  // A CS rise wins over any SCK edge seen in the same cycle
  assign lead   = active & ~cs_rise & (cpol_q ? sck_fall : sck_rise);
  assign trail  = active & ~cs_rise & (cpol_q ? sck_rise : sck_fall);
  assign sample = cpha_q ? trail : lead;
  assign drive  = cpha_q ? lead : trail;

  // At CS fall the mode is not latched yet, so the live cpha decides the preload
  assign load   = (frame_start & ~cpha_i) | (drive & (bit_c_q == 3'd0));
  assign wr_acc = tx_wr_i & ~tx_full_q;

  always_comb begin
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    msb_d  = msb_q;
    if (frame_start) begin
      cpol_d = cpol_i;
      cpha_d = cpha_i;
      msb_d  = msb_lsb_i;
    end

    bit_c_d = bit_c_q;
    rx_sh_d = rx_sh_q;
    done_d  = 1'b0;
    if (frame_end) begin
      bit_c_d = 3'd0;
    end else if (sample) begin
      rx_sh_d = msb_q ? {rx_sh_q[6:0], mosi_s} : {mosi_s, rx_sh_q[7:1]};
      bit_c_d = bit_c_q + 3'd1;
      done_d  = (bit_c_q == 3'd7);
    end

    rx_valid_d = done_q;
    rx_data_d  = done_q ? rx_sh_q : rx_data_q;

    tx_sh_d   = tx_sh_q;
    hold_d    = hold_q;
    tx_full_d = tx_full_q;
    tx_udr_d  = 1'b0;
    if (load) begin
      if (tx_full_q) begin
        tx_sh_d   = hold_q;
        tx_full_d = 1'b0;
      end else if (tx_wr_i) begin
        tx_sh_d = tx_data_i;
      end else begin
        tx_sh_d  = UDR_BYTE;
        tx_udr_d = 1'b1;
      end
    end else begin
      if (drive) tx_sh_d = msb_q ? {tx_sh_q[6:0], 1'b0} : {1'b0, tx_sh_q[7:1]};
      if (wr_acc) begin
        hold_d    = tx_data_i;
        tx_full_d = 1'b1;
      end
    end

    miso_d = out_bit(tx_sh_q, msb_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mosi_q     <= '0;
      state_q    <= IDLE_s;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      msb_q      <= 1'b1;
      bit_c_q    <= 3'd0;
      rx_sh_q    <= 8'h00;
      tx_sh_q    <= 8'h00;
      hold_q     <= 8'h00;
      tx_full_q  <= 1'b0;
      tx_udr_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      mosi_q     <= mosi_d;
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      msb_q      <= msb_d;
      bit_c_q    <= bit_c_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      hold_q     <= hold_d;
      tx_full_q  <= tx_full_d;
      tx_udr_q   <= tx_udr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      miso_q     <= miso_d;
    end
  end

  assign tx_full_o     = tx_full_q;
  assign tx_udr_o      = tx_udr_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = active;

endmodule

// File: tb/tb_spi_slave_tx_rx.sv
// Bench for spi_slave_tx_rx: bit-banged SPI master, table of directed frames,
// randomized frames checked against a queue-based transmit model.
module tb_spi_slave_tx_rx;

  localparam int SYNC = 2;
  localparam int H    = SYNC + 5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cpol, cpha, msb_lsb;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full, tx_udr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sck, cs, mosi, miso, miso_oe;

  always #5 clk = ~clk;

  spi_slave_tx_rx #(.sync_st(SYNC)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .cpol_i        (cpol),
    .cpha_i        (cpha),
    .msb_lsb_i     (msb_lsb),
    .tx_data_i     (tx_data),
    .tx_wr_i       (tx_wr),
    .tx_full_o     (tx_full),
    .tx_udr_o      (tx_udr),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .spi_sck_i     (sck),
    .spi_cs_i      (cs),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe)
  );

  typedef struct packed {
    logic            cpol;
    logic            cpha;
    logic            msb;
    int              nb;
    logic            pre_en;
    logic [7:0]      pre;
    logic [2:0][7:0] mo;
    logic [2:0]      wr_en;
    logic [2:0][7:0] wr;
    logic            dbl_en;
    logic [7:0]      dbl;
    logic [2:0][7:0] exp_mi;
    int              exp_udr;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int udr_seen = 0;
  int m_udr = 0;
  logic [7:0] rx_q[$];
  logic [7:0] m_hold[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_q.push_back(rx_data);
    if (tx_udr === 1'b1) udr_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mdl_write(input logic [7:0] val);
    if (m_hold.size() == 0) m_hold.push_back(val);
  endtask

  task automatic mdl_load(output logic [7:0] e);
    if (m_hold.size() != 0) e = m_hold.pop_front();
    else begin
      e = 8'h00;
      m_udr++;
    end
  endtask

  task automatic do_write(input logic [7:0] val);
    tx_data = val;
    tx_wr   = 1'b1;
    wait_clk(1);
    tx_wr   = 1'b0;
    mdl_write(val);
    chk("tx_full", 32'(tx_full), 32'(m_hold.size()));
  endtask

  task automatic chk_reset_outs();
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_tx_full", 32'(tx_full), 32'h0);
    chk("rst_tx_udr", 32'(tx_udr), 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_miso_oe", 32'(miso_oe), 32'h0);
  endtask

  task automatic sck_cycle(input logic d);
    mosi = d;
    wait_clk(H);
    sck = ~cpol;
    wait_clk(H);
    sck = cpol;
  endtask

  task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = msb_lsb ? 7 - i : i;
      if (!cpha) begin
        mosi = mo[idx];
        wait_clk(H);
        mi[idx] = miso;
        sck = ~cpol;
        wait_clk(H);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = mo[idx];
        wait_clk(H);
        mi[idx] = miso;
        sck = cpol;
        wait_clk(H);
      end
    end
    wait_clk(H);
  endtask

  task automatic post_wr(input vec_t v, input int k);
    if (v.wr_en[k]) do_write(v.wr[k]);
    if (k == 0 && v.dbl_en) do_write(v.dbl);
  endtask

  task automatic run_frame(input vec_t v, input bit tbl);
    logic [7:0] e, got;
    logic [7:0] em [4];
    int udr0, mudr0, nrx0;
    cpol = v.cpol; cpha = v.cpha; msb_lsb = v.msb; sck = v.cpol;
    wait_clk(H);
    if (v.pre_en) do_write(v.pre);
    udr0 = udr_seen; mudr0 = m_udr; nrx0 = rx_q.size();
    cs = 1'b0;
    wait_clk(H);
    chk("miso_oe_on", 32'(miso_oe), 32'h1);
    if (!v.cpha) begin
      mdl_load(em[0]);
      post_wr(v, 0);
    end
    for (int b = 0; b < v.nb; b++) begin
      xfer_byte(v.mo[b], got);
      mdl_load(e);
      if (v.cpha) begin
        em[b] = e;
        post_wr(v, b);
      end else begin
        em[b+1] = e;
        if (b + 1 < 3) post_wr(v, b + 1);
      end
      chk("miso_byte", 32'(got), 32'(em[b]));
      if (tbl) chk("miso_tbl", 32'(got), 32'(v.exp_mi[b]));
    end
    cs = 1'b1;
    wait_clk(H);
    chk("miso_oe_off", 32'(miso_oe), 32'h0);
    chk("rx_count", 32'(rx_q.size() - nrx0), 32'(v.nb));
    for (int b = 0; b < v.nb; b++)
      if (nrx0 + b < rx_q.size()) chk("rx_byte", 32'(rx_q[nrx0+b]), 32'(v.mo[b]));
    chk("udr_count", 32'(udr_seen - udr0), 32'(m_udr - mudr0));
    if (tbl) chk("udr_tbl", 32'(udr_seen - udr0), 32'(v.exp_udr));
  endtask

  function automatic vec_t mk(input logic cp, input logic ch, input logic ms, input int nb,
                              input logic pe, input logic [7:0] pv, input logic [23:0] mo,
                              input logic [2:0] we, input logic [23:0] wr, input logic de,
                              input logic [7:0] dv, input logic [23:0] em, input int eu);
    vec_t v;
    v = '0;
    v.cpol = cp; v.cpha = ch; v.msb = ms; v.nb = nb;
    v.pre_en = pe; v.pre = pv; v.mo = mo; v.wr_en = we; v.wr = wr;
    v.dbl_en = de; v.dbl = dv; v.exp_mi = em; v.exp_udr = eu;
    return v;
  endfunction

  vec_t vecs [6];
  vec_t rv;
  logic [7:0] e_part;
  int nrx_save, udr_save, mudr_save;

  initial begin
    //            cpol cpha msb nb pre  preval  mosi{2,1,0}  wr_en   wr{2,1,0}  dbl  dblval exp_mi{2,1,0} udr
    vecs[0] = mk(1'b0, 1'b0, 1'b1, 1, 1'b1, 8'hA5, 24'h00003C, 3'b000, 24'h000000, 1'b0, 8'h00, 24'h0000A5, 1);
    vecs[1] = mk(1'b1, 1'b1, 1'b0, 1, 1'b1, 8'h81, 24'h00007E, 3'b000, 24'h000000, 1'b0, 8'h00, 24'h000081, 0);
    vecs[2] = mk(1'b0, 1'b1, 1'b1, 3, 1'b1, 8'h11, 24'hC3C2C1, 3'b011, 24'h003322, 1'b0, 8'h00, 24'h332211, 0);
    vecs[3] = mk(1'b1, 1'b0, 1'b0, 3, 1'b1, 8'h11, 24'h5A6B7C, 3'b111, 24'h443322, 1'b0, 8'h00, 24'h332211, 0);
    vecs[4] = mk(1'b0, 1'b0, 1'b1, 2, 1'b0, 8'h00, 24'h00E15A, 3'b011, 24'h00996B, 1'b1, 8'h77, 24'h006B00, 1);
    vecs[5] = mk(1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h5E, 24'h0000E7, 3'b000, 24'h000000, 1'b0, 8'h00, 24'h00005E, 1);

    rstn = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_wr = 1'b0; tx_data = 8'h00; cpol = 1'b0; cpha = 1'b0; msb_lsb = 1'b1;
    #12;
    chk_reset_outs();
    wait_clk(1);
    rstn = 1'b1;
    wait_clk(4);
    chk_reset_outs();

    for (int i = 0; i < 5; i++) run_frame(vecs[i], 1'b1);

    // CS abandoned after five SCK cycles: partial byte must vanish
    cpol = 1'b0; cpha = 1'b0; msb_lsb = 1'b1; sck = 1'b0;
    wait_clk(H);
    do_write(8'hC3);
    nrx_save = rx_q.size(); udr_save = udr_seen; mudr_save = m_udr;
    cs = 1'b0;
    wait_clk(H);
    mdl_load(e_part);
    for (int i = 0; i < 5; i++) sck_cycle(1'($urandom_range(0, 1)));
    wait_clk(3);
    chk("part_oe_before", 32'(miso_oe), 32'h1);
    cs = 1'b1;
    wait_clk(H);
    chk("part_oe_after", 32'(miso_oe), 32'h0);
    chk("part_no_rx", 32'(rx_q.size() - nrx_save), 32'h0);
    chk("part_udr", 32'(udr_seen - udr_save), 32'(m_udr - mudr_save));
    run_frame(vecs[5], 1'b1);

    // asynchronous reset in the middle of a byte
    cpol = 1'b0; cpha = 1'b0; msb_lsb = 1'b1; sck = 1'b0;
    wait_clk(H);
    do_write(8'h9C);
    nrx_save = rx_q.size();
    cs = 1'b0;
    wait_clk(H);
    mdl_load(e_part);
    do_write(8'h55);
    for (int i = 0; i < 3; i++) sck_cycle(1'b1);
    mosi = 1'b0;
    wait_clk(H);
    sck = 1'b1;
    wait_clk(2);
    #2 rstn = 1'b0;
    #1 chk_reset_outs();
    cs = 1'b1; sck = 1'b0;
    m_hold.delete();
    wait_clk(3);
    rstn = 1'b1;
    wait_clk(H);
    chk("rst_no_rx", 32'(rx_q.size() - nrx_save), 32'h0);
    chk_reset_outs();
    run_frame(vecs[1], 1'b1);
    run_frame(vecs[0], 1'b1);

    for (int r = 0; r < 16; r++) begin
      rv = '0;
      rv.cpol   = 1'($urandom_range(0, 1));
      rv.cpha   = 1'($urandom_range(0, 1));
      rv.msb    = 1'($urandom_range(0, 1));
      rv.nb     = int'($urandom_range(1, 3));
      rv.pre_en = 1'($urandom_range(0, 1));
      rv.pre    = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        rv.mo[k]    = 8'($urandom);
        rv.wr_en[k] = 1'($urandom_range(0, 1));
        rv.wr[k]    = 8'($urandom);
      end
      rv.dbl_en = 1'($urandom_range(0, 1));
      rv.dbl    = 8'($urandom);
      run_frame(rv, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
